// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS write-back stage: load formats, defaults and
// the control portion of the MEM/WB pipeline register.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int CNT_W_DEF  = 32;

    typedef enum logic [2:0] {
        LD_FULL  = 3'b000,
        LD_W     = 3'b001,
        LD_H     = 3'b010,
        LD_HU    = 3'b011,
        LD_B     = 3'b100,
        LD_BU    = 3'b101,
        LD_WU    = 3'b110,
        LD_FULL2 = 3'b111
    } load_type_t;

    // Width-independent fields; the parametrised data/address fields sit beside it.
    typedef struct packed {
        logic       valid;
        logic       to_reg;
        logic       reg_write;
        load_type_t load_type;
    } mem_wb_t;

    function automatic logic is_signed_load(input load_type_t lt);
        logic res;
        case (lt)
            LD_W, LD_H, LD_B: res = 1'b1;
            default:          res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_stage_pipe_load_align.sv
// Little-endian sub-word load extraction with sign or zero extension.
module load_align
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0]            rdata,
    input  logic [$clog2(DATA_W/8)-1:0]  addr_lo,
    input  load_type_t                   load_type,
    output logic [DATA_W-1:0]            ext_data
);

    localparam int OFF_W = $clog2(DATA_W/8);
    localparam logic [OFF_W-1:0] H_MASK = ~OFF_W'(1'b1);
    localparam logic [OFF_W-1:0] W_MASK = ~OFF_W'(2'b11);

    logic [OFF_W-1:0] h_off_s;
    logic [OFF_W-1:0] w_off_s;
    logic [7:0]       b_s;
    logic [15:0]      h_s;
    logic [31:0]      w_s;
    logic             sgn_s;

    // Lane selection: the low offset bits below the access size are dropped.
    always_comb begin
        h_off_s = addr_lo & H_MASK;
        w_off_s = addr_lo & W_MASK;
        b_s     = 8'(rdata >> {addr_lo, 3'b000});
        h_s     = 16'(rdata >> {h_off_s, 3'b000});
        w_s     = 32'(rdata >> {w_off_s, 3'b000});
        sgn_s   = is_signed_load(load_type);
    end

    // Extension to the full datapath width.
    always_comb begin
        ext_data = rdata;
        case (load_type)
            LD_W, LD_WU: begin
                if (sgn_s) begin
                    ext_data = DATA_W'(signed'(w_s));
                end else begin
                    ext_data = DATA_W'(w_s);
                end
            end
            LD_H, LD_HU: begin
                if (sgn_s) begin
                    ext_data = DATA_W'(signed'(h_s));
                end else begin
                    ext_data = DATA_W'(h_s);
                end
            end
            LD_B, LD_BU: begin
                if (sgn_s) begin
                    ext_data = DATA_W'(signed'(b_s));
                end else begin
                    ext_data = DATA_W'(b_s);
                end
            end
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// MIPS write-back stage: MEM/WB register with stall/flush, load alignment,
// register-file write port, retire pulse and retired-instruction counter.
module wb_stage_pipe
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mem_valid,
    input  logic                          mem_to_reg,
    input  logic                          mem_reg_write,
    input  logic [2:0]                    mem_load_type,
    input  logic [$clog2(DATA_W/8)-1:0]   mem_addr_lo,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic [DATA_W-1:0]             mem_alu_result,
    input  logic [REG_AW-1:0]             mem_dest,
    input  logic                          wb_stall,
    input  logic                          wb_flush,
    output logic                          wb_en,
    output logic [REG_AW-1:0]             wb_addr,
    output logic [DATA_W-1:0]             wb_data,
    output logic                          wb_retire,
    output logic [CNT_W-1:0]              retire_count
);

    localparam int OFF_W = $clog2(DATA_W/8);

    mem_wb_t             ctrl_q,    ctrl_d;
    logic [OFF_W-1:0]    addr_lo_q, addr_lo_d;
    logic [DATA_W-1:0]   rdata_q,   rdata_d;
    logic [DATA_W-1:0]   alu_q,     alu_d;
    logic [REG_AW-1:0]   dest_q,    dest_d;
    logic                fresh_q,   fresh_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [DATA_W-1:0]   ld_data_s;

    // Next-state for the pipeline register; flush outranks stall.
    always_comb begin
        ctrl_d    = ctrl_q;
        addr_lo_d = addr_lo_q;
        rdata_d   = rdata_q;
        alu_d     = alu_q;
        dest_d    = dest_q;
        fresh_d   = 1'b0;
        if (wb_flush) begin
            ctrl_d.valid = 1'b0;
        end else if (wb_stall) begin
            fresh_d = 1'b0;
        end else begin
            ctrl_d.valid     = mem_valid;
            ctrl_d.to_reg    = mem_to_reg;
            ctrl_d.reg_write = mem_reg_write;
            ctrl_d.load_type = load_type_t'(mem_load_type);
            addr_lo_d        = mem_addr_lo;
            rdata_d          = mem_rdata;
            alu_d            = mem_alu_result;
            dest_d           = mem_dest;
            fresh_d          = mem_valid;
        end
    end

    // The counter advances at capture so it already includes the instruction
    // whose retire pulse is being presented.
    always_comb begin
        if (fresh_d) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '{valid: 1'b0, to_reg: 1'b0, reg_write: 1'b0, load_type: LD_FULL};
            addr_lo_q <= '0;
            rdata_q   <= '0;
            alu_q     <= '0;
            dest_q    <= '0;
            fresh_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            addr_lo_q <= addr_lo_d;
            rdata_q   <= rdata_d;
            alu_q     <= alu_d;
            dest_q    <= dest_d;
            fresh_q   <= fresh_d;
            cnt_q     <= cnt_d;
        end
    end

    load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .rdata     (rdata_q),
        .addr_lo   (addr_lo_q),
        .load_type (ctrl_q.load_type),
        .ext_data  (ld_data_s)
    );

    // Register-file write port and retire outputs.
    always_comb begin
        wb_en        = ctrl_q.valid & ctrl_q.reg_write & (dest_q != '0);
        wb_addr      = dest_q;
        if (ctrl_q.to_reg) begin
            wb_data = ld_data_s;
        end else begin
            wb_data = alu_q;
        end
        wb_retire    = ctrl_q.valid & fresh_q;
        retire_count = cnt_q;
    end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: a 32-bit and a 64-bit/4-bit-counter instance
// share stimulus and are checked against a behavioural model every cycle.
module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_valid = 1'b0, mem_to_reg = 1'b0, mem_reg_write = 1'b0;
    logic [2:0]  mem_load_type = 3'd0;
    logic [2:0]  mem_addr_lo = 3'd0;
    logic [63:0] mem_rdata = 64'd0, mem_alu = 64'd0;
    logic [4:0]  mem_dest = 5'd0;
    logic        wb_stall = 1'b0, wb_flush = 1'b0;

    logic        en32, ret32, en64, ret64;
    logic [4:0]  addr32, addr64;
    logic [31:0] data32, cnt32;
    logic [63:0] data64;
    logic [3:0]  cnt64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_stage_pipe #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_to_reg(mem_to_reg),
        .mem_reg_write(mem_reg_write), .mem_load_type(mem_load_type),
        .mem_addr_lo(mem_addr_lo[1:0]), .mem_rdata(mem_rdata[31:0]),
        .mem_alu_result(mem_alu[31:0]), .mem_dest(mem_dest), .wb_stall(wb_stall),
        .wb_flush(wb_flush), .wb_en(en32), .wb_addr(addr32), .wb_data(data32),
        .wb_retire(ret32), .retire_count(cnt32));

    wb_stage_pipe #(.DATA_W(64), .REG_AW(5), .CNT_W(4)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_to_reg(mem_to_reg),
        .mem_reg_write(mem_reg_write), .mem_load_type(mem_load_type),
        .mem_addr_lo(mem_addr_lo), .mem_rdata(mem_rdata),
        .mem_alu_result(mem_alu), .mem_dest(mem_dest), .wb_stall(wb_stall),
        .wb_flush(wb_flush), .wb_en(en64), .wb_addr(addr64), .wb_data(data64),
        .wb_retire(ret64), .retire_count(cnt64));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Load result from first principles: pick the naturally aligned lane of
    // the access size within the word, then extend it.
    function automatic logic [63:0] model_load(input logic [63:0] rd, input int unsigned addr,
                                               input int unsigned lt, input int unsigned dw);
        int unsigned size, base;
        bit          sgn;
        logic [63:0] v, m;
        case (lt)
            1: begin size = 4; sgn = 1'b1; end
            6: begin size = 4; sgn = 1'b0; end
            2: begin size = 2; sgn = 1'b1; end
            3: begin size = 2; sgn = 1'b0; end
            4: begin size = 1; sgn = 1'b1; end
            5: begin size = 1; sgn = 1'b0; end
            default: begin size = dw / 8; sgn = 1'b0; end
        endcase
        base = addr % (dw / 8);
        base = base - (base % size);
        v = rd >> (base * 8);
        if (size < 8) begin
            m = (64'd1 << (size * 8)) - 64'd1;
            v = v & m;
            if (sgn && v[size*8-1]) v = v | ~m;
        end
        if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    // Model of what is presented to write-back.
    bit          m_valid = 1'b0, m_new = 1'b0, m_zero = 1'b1;
    bit          m_to_reg = 1'b0, m_rw = 1'b0;
    int unsigned m_lt = 0, m_addr = 0;
    logic [63:0] m_rd = 64'd0, m_alu = 64'd0;
    logic [4:0]  m_dest = 5'd0;
    int unsigned m_cnt32 = 0, m_cnt4 = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_new = 1'b0; m_zero = 1'b1;
            m_to_reg = 1'b0; m_rw = 1'b0; m_lt = 0; m_addr = 0;
            m_rd = 64'd0; m_alu = 64'd0; m_dest = 5'd0;
            m_cnt32 = 0; m_cnt4 = 0;
        end else if (wb_flush) begin
            m_valid = 1'b0; m_new = 1'b0; m_zero = 1'b0;
        end else if (wb_stall) begin
            m_new = 1'b0;
        end else begin
            m_valid = mem_valid; m_new = mem_valid; m_zero = 1'b0;
            m_to_reg = mem_to_reg; m_rw = mem_reg_write; m_lt = mem_load_type;
            m_addr = mem_addr_lo; m_rd = mem_rdata; m_alu = mem_alu; m_dest = mem_dest;
            if (mem_valid) begin
                m_cnt32 = m_cnt32 + 1;
                m_cnt4  = (m_cnt4 + 1) % 16;
            end
        end
    end

    logic [63:0] e32, e64;
    bit          e_en;

    always @(negedge clk) begin
        e_en = m_valid && m_rw && (m_dest != 5'd0);
        if (m_to_reg) begin
            e32 = model_load(m_rd, m_addr, m_lt, 32);
            e64 = model_load(m_rd, m_addr, m_lt, 64);
        end else begin
            e32 = m_alu & 64'h0000_0000_FFFF_FFFF;
            e64 = m_alu;
        end
        chk("en32", {63'd0, en32}, {63'd0, e_en});
        chk("en64", {63'd0, en64}, {63'd0, e_en});
        chk("retire32", {63'd0, ret32}, {63'd0, m_valid && m_new});
        chk("retire64", {63'd0, ret64}, {63'd0, m_valid && m_new});
        chk("count32", {32'd0, cnt32}, 64'(m_cnt32));
        chk("count64", {60'd0, cnt64}, 64'(m_cnt4));
        if (m_valid || m_zero) begin
            chk("addr32", {59'd0, addr32}, {59'd0, m_dest});
            chk("addr64", {59'd0, addr64}, {59'd0, m_dest});
            chk("data32", {32'd0, data32}, e32);
            chk("data64", data64, e64);
        end
    end

    task automatic step(input bit v, input bit tr, input bit rw, input logic [2:0] lt,
                        input logic [2:0] a, input logic [63:0] rd, input logic [63:0] alu,
                        input logic [4:0] d, input bit st, input bit fl);
        @(negedge clk);
        mem_valid = v; mem_to_reg = tr; mem_reg_write = rw; mem_load_type = lt;
        mem_addr_lo = a; mem_rdata = rd; mem_alu = alu; mem_dest = d;
        wb_stall = st; wb_flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    localparam logic [63:0] RD_A = 64'hA5A5A5A5_87654321;
    localparam logic [63:0] RD_B = 64'h80000000_12345678;

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_en", {63'd0, en32}, 64'd0);
        chk("rst_data", {32'd0, data32}, 64'd0);
        chk("rst_count", {32'd0, cnt32}, 64'd0);

        step(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 64'd0, 64'h11111111_43242243, 5'd8, 1'b0, 1'b0);
        chk("t1_en", {63'd0, en32}, 64'd1);
        chk("t1_addr", {59'd0, addr32}, 64'd8);
        chk("t1_data", {32'd0, data32}, 64'h43242243);
        chk("t1_retire", {63'd0, ret32}, 64'd1);
        chk("t1_count", {32'd0, cnt32}, 64'd1);

        step(1'b1, 1'b1, 1'b1, 3'd4, 3'd3, RD_A, 64'd0, 5'd9, 1'b0, 1'b0);
        chk("lb3", {32'd0, data32}, 64'hFFFFFF87);
        chk("lb3_64", data64, 64'hFFFFFFFF_FFFFFF87);
        step(1'b1, 1'b1, 1'b1, 3'd5, 3'd3, RD_A, 64'd0, 5'd9, 1'b0, 1'b0);
        chk("lbu3", {32'd0, data32}, 64'h00000087);
        step(1'b1, 1'b1, 1'b1, 3'd2, 3'd0, RD_A, 64'd0, 5'd9, 1'b0, 1'b0);
        chk("lh0", {32'd0, data32}, 64'h00004321);
        step(1'b1, 1'b1, 1'b1, 3'd2, 3'd2, RD_A, 64'd0, 5'd9, 1'b0, 1'b0);
        chk("lh2", {32'd0, data32}, 64'hFFFF8765);
        step(1'b1, 1'b1, 1'b1, 3'd3, 3'd3, RD_A, 64'd0, 5'd9, 1'b0, 1'b0);
        chk("lhu3", {32'd0, data32}, 64'h00008765);
        step(1'b1, 1'b1, 1'b1, 3'd1, 3'd4, RD_B, 64'd0, 5'd10, 1'b0, 1'b0);
        chk("lw4_64", data64, 64'hFFFFFFFF_80000000);
        chk("lw4_32", {32'd0, data32}, 64'h12345678);
        step(1'b1, 1'b1, 1'b1, 3'd6, 3'd4, RD_B, 64'd0, 5'd10, 1'b0, 1'b0);
        chk("lwu4_64", data64, 64'h00000000_80000000);
        step(1'b1, 1'b1, 1'b1, 3'd7, 3'd5, RD_B, 64'd0, 5'd10, 1'b0, 1'b0);
        chk("full2_64", data64, RD_B);

        step(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 64'd0, 64'h1234, 5'd0, 1'b0, 1'b0);
        chk("r0_en", {63'd0, en32}, 64'd0);
        chk("r0_retire", {63'd0, ret32}, 64'd1);
        chk("r0_count", {32'd0, cnt32}, 64'd10);

        step(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 64'd0, 64'h0BADF00D, 5'd12, 1'b0, 1'b0);
        chk("stall0_retire", {63'd0, ret32}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 64'd0, 64'hDEAD, 5'd13, 1'b1, 1'b0);
            chk("stall_en", {63'd0, en32}, 64'd1);
            chk("stall_data", {32'd0, data32}, 64'h0BADF00D);
            chk("stall_retire", {63'd0, ret32}, 64'd0);
            chk("stall_count", {32'd0, cnt32}, 64'd11);
        end
        idle();

        step(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 64'd0, 64'h55, 5'd14, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 64'd0, 64'h66, 5'd15, 1'b1, 1'b1);
        chk("fs_en", {63'd0, en32}, 64'd0);
        chk("fs_retire", {63'd0, ret32}, 64'd0);
        chk("fs_count", {32'd0, cnt32}, 64'd12);
        step(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 64'd0, 64'h77, 5'd16, 1'b0, 1'b1);
        chk("fl_retire", {63'd0, ret32}, 64'd0);
        chk("fl_count", {32'd0, cnt32}, 64'd12);

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 64'd0, 64'(i), 5'(i + 1), 1'b0, 1'b0);
            chk("b2b_retire", {63'd0, ret32}, 64'd1);
            chk("b2b_count", {32'd0, cnt32}, 64'(13 + i));
        end
        step(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 64'd0, 64'h99, 5'd3, 1'b0, 1'b0);
        chk("store_en", {63'd0, en32}, 64'd0);
        chk("store_retire", {63'd0, ret32}, 64'd1);
        idle();

        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 64'd0, 64'(i), 5'd7, 1'b0, 1'b0);
        end
        chk("pre_wrap64", {60'd0, cnt64}, 64'd15);
        step(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 64'd0, 64'h100, 5'd7, 1'b0, 1'b0);
        chk("wrap64", {60'd0, cnt64}, 64'd0);
        chk("wrap64_retire", {63'd0, ret64}, 64'd1);
        chk("nowrap32", {32'd0, cnt32}, 64'd16);

        step(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 64'd0, 64'hABCD, 5'd5, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 64'd0, 64'hEEEE, 5'd6, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_en", {63'd0, en32}, 64'd0);
        chk("mid_rst_addr", {59'd0, addr64}, 64'd0);
        chk("mid_rst_data", data64, 64'd0);
        chk("mid_rst_retire", {63'd0, ret64}, 64'd0);
        chk("mid_rst_count", {32'd0, cnt32}, 64'd0);
        mem_valid = 1'b0; wb_stall = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle();
        chk("post_rst_retire", {63'd0, ret32}, 64'd0);
        chk("post_rst_count", {32'd0, cnt32}, 64'd0);
        idle();

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
